tone_gen: RTL and testbench

Square-wave tone generator sitting directly downstream of the note-to-period lookup. Consumes the half-period word (in prescaler ticks) for the current note, applies an octave shift, and produces a glitch-free 50 % duty square wave gated by a note-on signal. Period changes take effect only at waveform edges. Note release always completes the current high half-cycle before going silent.

---
 rtl/tone_gen_if.sv | 30 +++
 rtl/tone_gen.sv | 117 +++++++++++
 tb/tb_tone_gen.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_gen_if.sv
// -----------------------------------------------------------------------------
// tone_gen_if
//   Bundles the note inputs and the tone outputs of tone_gen.
//   halfCntPeriod_i : base half period in prescaler ticks (BW-1 bits, unsigned)
//   octave_i        : signed octave shift, -4..+3
//   gate_i          : note on (1) / off (0)
//   tone_o          : square-wave output
//   active_o        : high whenever the generator is not idle
//   master : drives the note inputs (note lookup / testbench)
//   slave  : the tone generator itself
// -----------------------------------------------------------------------------
interface tone_gen_if #(
  parameter int BW = 11
);
  logic [BW-2:0] halfCntPeriod_i;
  logic [2:0]    octave_i;
  logic          gate_i;
  logic          tone_o;
  logic          active_o;

  modport master (
    output halfCntPeriod_i, octave_i, gate_i,
    input  tone_o, active_o
  );

  modport slave (
    input  halfCntPeriod_i, octave_i, gate_i,
    output tone_o, active_o
  );
endinterface

// File: rtl/tone_gen.sv
// -----------------------------------------------------------------------------
// tone_gen
//   Glitch-free 50 % duty square-wave tone generator. The half period (in
//   prescaler ticks) is octave-shifted, latched at every waveform edge, and
//   counted out with a tick prescaler. Releasing the gate always finishes the
//   current high half-cycle before going silent.
//   clk_i : system clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : tone_gen_if.slave (half period, octave, gate in; tone, active out)
// -----------------------------------------------------------------------------
module tone_gen #(
  parameter int BW       = 11,
  parameter int PRESCALE = 140
) (
  input  logic        clk_i,
  input  logic        rst_i,
  tone_gen_if.slave   bus
);

  localparam int CW  = BW + 3;
  localparam int PSW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e          state_q;
  logic            tone_q;
  logic            active_q;
  logic [PSW-1:0]  psc_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   per_q;

  logic [CW-1:0]   base;
  logic [2:0]      lshift;
  logic [CW-1:0]   eff;
  logic            eff_zero;
  logic            tick;
  logic            toggle;
  logic            tone_d;
  logic            go_idle;

  // Octave shift: non-negative shifts right (higher pitch), negative shifts
  // left (lower pitch). CW leaves four spare bits so a shift of 4 cannot
  // overflow.
  assign base   = {4'b0000, bus.halfCntPeriod_i};
  assign lshift = ~bus.octave_i + 3'd1;

  // NOTE: every signal assigned in always_comb gets a value on every path;
  // a missing else branch would infer a latch.
  always_comb begin
    eff = base;
    if (!bus.octave_i[2]) eff = base >> bus.octave_i;
    else                  eff = base << lshift;
  end

  assign eff_zero = (eff == '0);
  assign tick     = (psc_q == PSW'(PRESCALE - 1));
  // per_q is never zero outside IDLE, so per_q-1 does not wrap while counting.
  assign toggle   = tick && (cnt_q == per_q - CW'(1));
  assign tone_d   = toggle ? ~tone_q : tone_q;

  // Leave RUN/STOP when a reload mutes the tone, or when the gate is low and
  // the waveform is (or is about to be) low. A gate drop on a rising toggle
  // keeps the note alive in STOP until its high half-cycle completes.
  assign go_idle  = (toggle && eff_zero) || (!bus.gate_i && !tone_d);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      tone_q   <= 1'b0;
      active_q <= 1'b0;
      psc_q    <= '0;
      cnt_q    <= '0;
      per_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.gate_i && !eff_zero) begin
            state_q  <= S_RUN;
            tone_q   <= 1'b1;
            active_q <= 1'b1;
            per_q    <= eff;
            psc_q    <= '0;
            cnt_q    <= '0;
          end
        end

        // RUN and STOP count identically; they differ only in gate handling.
        default: begin
          if (toggle) per_q <= eff;
          if (go_idle) begin
            state_q  <= S_IDLE;
            tone_q   <= 1'b0;
            active_q <= 1'b0;
            psc_q    <= '0;
            cnt_q    <= '0;
          end else begin
            state_q  <= bus.gate_i ? S_RUN : S_STOP;
            tone_q   <= tone_d;
            active_q <= 1'b1;
            psc_q    <= tick ? '0 : psc_q + PSW'(1);
            if (tick) cnt_q <= toggle ? '0 : cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.tone_o   = tone_q;
  assign bus.active_o = active_q;

endmodule

// File: tb/tb_tone_gen.sv
// -----------------------------------------------------------------------------
// tb_tone_gen
//   Self-checking bench for tone_gen (BW=11, PRESCALE=4). A behavioural model
//   tracks the note as "clocks remaining in the current half-cycle" and is
//   compared with the DUT on every falling clock edge; directed tests also
//   measure half-cycle lengths against fixed expected clock counts.
// -----------------------------------------------------------------------------
module tb_tone_gen;

  localparam int BW = 11;
  localparam int P  = 4;

  logic clk = 1'b0;
  logic rst;

  tone_gen_if #(.BW(BW)) bus ();

  tone_gen #(.BW(BW), .PRESCALE(P)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit m_act  = 1'b0;
  bit m_tone = 1'b0;
  int m_rem  = 0;

  // Per-test record of model disagreements
  int  mis       = 0;
  time mis_t     = 0;
  bit  mis_tone  = 1'b0;
  bit  mis_act   = 1'b0;

  function automatic int eff_f(input int h, input logic [2:0] o);
    int s;
    s = $signed(o);
    if (s >= 0) return h >> s;
    return h << (-s);
  endfunction

  // One clock: update the model from the inputs seen at the rising edge,
  // then sample the DUT on the falling edge.
  task automatic cyc();
    int e;
    @(posedge clk);
    e = eff_f(int'(bus.halfCntPeriod_i), bus.octave_i);
    if (rst) begin
      m_act = 0; m_tone = 0; m_rem = 0;
    end else if (!m_act) begin
      if (bus.gate_i && e != 0) begin
        m_act = 1; m_tone = 1; m_rem = e * P;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_tone = !m_tone;
        if (e == 0) begin m_act = 0; m_tone = 0; end
        else m_rem = e * P;
      end
      if (!bus.gate_i && !m_tone) begin m_act = 0; m_tone = 0; end
    end
    @(negedge clk);
    if (bus.tone_o !== m_tone || bus.active_o !== m_act) begin
      mis++;
      if (mis == 1) begin
        mis_t = $time; mis_tone = bus.tone_o; mis_act = bus.active_o;
      end
    end
  endtask

  task automatic set_in(input int h, input logic [2:0] o, input logic g);
    bus.halfCntPeriod_i = (BW-1)'(h);
    bus.octave_i        = o;
    bus.gate_i          = g;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.gate_i = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    mis = 0;
  endtask

  // Counts consecutive samples (starting with the current one) at level lvl.
  task automatic count_level(input logic lvl, output int n);
    n = 0;
    while (bus.tone_o === lvl && n < 30000) begin
      n++;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(682, 3'd0, 1'b1);
    cyc(); cyc();
    n_chk++;
    if (bus.tone_o !== 1'b0 || bus.active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: tone=%b active=%b, want 0 0", bus.tone_o, bus.active_o);
    end
    bus.gate_i = 1'b0;
    rst = 1'b0;
    mis = 0;
    repeat (3) cyc();
    n_chk++;
    if (bus.active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: active=%b, want 0", bus.active_o);
    end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    set_in(682, 3'd0, 1'b1);
    cyc();
    n_chk++;
    if (bus.active_o !== 1'b1 || bus.tone_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_start: tone=%b active=%b, want 1 1", bus.tone_o, bus.active_o);
    end
    count_level(1'b1, n);
    n_chk++;
    if (n !== 2728) begin n_fail++; $display("FAIL basic_high1: %0d clocks, want 2728", n); end
    count_level(1'b0, n);
    n_chk++;
    if (n !== 2728) begin n_fail++; $display("FAIL basic_low: %0d clocks, want 2728", n); end
    count_level(1'b1, n);
    n_chk++;
    if (n !== 2728) begin n_fail++; $display("FAIL basic_high2: %0d clocks, want 2728", n); end
    n_chk++;
    if (mis !== 0) begin
      n_fail++;
      $display("FAIL basic_model: %0d bad cycles, first @%0t tone=%b active=%b", mis, mis_t, mis_tone, mis_act);
    end
  endtask

  task automatic test_octave();
    int n;
    do_reset();
    set_in(682, 3'd1, 1'b1);
    cyc();
    count_level(1'b1, n);
    n_chk++;
    if (n !== 1364) begin n_fail++; $display("FAIL oct_plus1: %0d clocks, want 1364", n); end

    do_reset();
    set_in(682, 3'b110, 1'b1);
    cyc();
    count_level(1'b1, n);
    n_chk++;
    if (n !== 10912) begin n_fail++; $display("FAIL oct_minus2: %0d clocks, want 10912", n); end

    // per == 1: toggle on every tick
    do_reset();
    set_in(2, 3'd1, 1'b1);
    cyc();
    count_level(1'b1, n);
    n_chk++;
    if (n !== P) begin n_fail++; $display("FAIL per_one_high: %0d clocks, want %0d", n, P); end
    count_level(1'b0, n);
    n_chk++;
    if (n !== P) begin n_fail++; $display("FAIL per_one_low: %0d clocks, want %0d", n, P); end

    // Shifted to zero: muted, never leaves IDLE
    do_reset();
    set_in(5, 3'd3, 1'b1);
    repeat (6) cyc();
    n_chk++;
    if (bus.tone_o !== 1'b0 || bus.active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mute: tone=%b active=%b, want 0 0", bus.tone_o, bus.active_o);
    end
    n_chk++;
    if (mis !== 0) begin
      n_fail++;
      $display("FAIL octave_model: %0d bad cycles, first @%0t tone=%b active=%b", mis, mis_t, mis_tone, mis_act);
    end
  endtask

  task automatic test_midchange();
    int n;
    do_reset();
    set_in(682, 3'd0, 1'b1);
    cyc();
    n = 0;
    while (bus.tone_o === 1'b1 && n < 30000) begin
      if (n == 1364) bus.halfCntPeriod_i = (BW-1)'(384);
      n++;
      cyc();
    end
    n_chk++;
    if (n !== 2728) begin n_fail++; $display("FAIL mid_current: %0d clocks, want 2728", n); end
    count_level(1'b0, n);
    n_chk++;
    if (n !== 1536) begin n_fail++; $display("FAIL mid_next_low: %0d clocks, want 1536", n); end
    count_level(1'b1, n);
    n_chk++;
    if (n !== 1536) begin n_fail++; $display("FAIL mid_next_high: %0d clocks, want 1536", n); end
    n_chk++;
    if (mis !== 0) begin
      n_fail++;
      $display("FAIL mid_model: %0d bad cycles, first @%0t tone=%b active=%b", mis, mis_t, mis_tone, mis_act);
    end
  endtask

  task automatic test_release();
    int n;
    do_reset();
    set_in(682, 3'd0, 1'b1);
    cyc();
    repeat (1000) cyc();
    bus.gate_i = 1'b0;
    cyc();
    n_chk++;
    if (bus.active_o !== 1'b1 || bus.tone_o !== 1'b1) begin
      n_fail++;
      $display("FAIL release_hold: tone=%b active=%b, want 1 1", bus.tone_o, bus.active_o);
    end
    count_level(1'b1, n);
    n_chk++;
    if (n !== 1727) begin n_fail++; $display("FAIL release_high: %0d clocks, want 1727", n); end
    n_chk++;
    if (bus.active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL release_active: active=%b, want 0", bus.active_o);
    end
    // Release during the low phase
    bus.gate_i = 1'b1;
    cyc();
    count_level(1'b1, n);
    repeat (100) cyc();
    bus.gate_i = 1'b0;
    cyc();
    n_chk++;
    if (bus.active_o !== 1'b0 || bus.tone_o !== 1'b0) begin
      n_fail++;
      $display("FAIL release_low: tone=%b active=%b, want 0 0", bus.tone_o, bus.active_o);
    end
    n_chk++;
    if (mis !== 0) begin
      n_fail++;
      $display("FAIL release_model: %0d bad cycles, first @%0t tone=%b active=%b", mis, mis_t, mis_tone, mis_act);
    end
  endtask

  task automatic test_retrigger();
    int n;
    do_reset();
    set_in(682, 3'd0, 1'b1);
    cyc();
    repeat (500) cyc();
    bus.gate_i = 1'b0;
    repeat (300) cyc();
    bus.gate_i = 1'b1;
    count_level(1'b1, n);
    n_chk++;
    if (n !== 1928) begin n_fail++; $display("FAIL retrig_high: %0d clocks, want 1928", n); end
    count_level(1'b0, n);
    n_chk++;
    if (n !== 2728) begin n_fail++; $display("FAIL retrig_low: %0d clocks, want 2728", n); end
    count_level(1'b1, n);
    n_chk++;
    if (n !== 2728) begin n_fail++; $display("FAIL retrig_high2: %0d clocks, want 2728", n); end
    n_chk++;
    if (mis !== 0) begin
      n_fail++;
      $display("FAIL retrig_model: %0d bad cycles, first @%0t tone=%b active=%b", mis, mis_t, mis_tone, mis_act);
    end
  endtask

  task automatic test_reset_midtone();
    int n;
    do_reset();
    set_in(682, 3'd0, 1'b1);
    cyc();
    repeat (700) cyc();
    rst = 1'b1;
    cyc();
    n_chk++;
    if (bus.tone_o !== 1'b0 || bus.active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_off: tone=%b active=%b, want 0 0", bus.tone_o, bus.active_o);
    end
    rst = 1'b0;
    cyc();
    n_chk++;
    if (bus.tone_o !== 1'b1 || bus.active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_restart: tone=%b active=%b, want 1 1", bus.tone_o, bus.active_o);
    end
    count_level(1'b1, n);
    n_chk++;
    if (n !== 2728) begin n_fail++; $display("FAIL midreset_full: %0d clocks, want 2728", n); end
    n_chk++;
    if (mis !== 0) begin
      n_fail++;
      $display("FAIL midreset_model: %0d bad cycles, first @%0t tone=%b active=%b", mis, mis_t, mis_tone, mis_act);
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    for (int seg = 0; seg < 60; seg++) begin
      set_in($urandom_range(0, 40), 3'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      hold = $urandom_range(1, 300);
      repeat (hold) cyc();
    end
    n_chk++;
    if (mis !== 0) begin
      n_fail++;
      $display("FAIL random_model: %0d bad cycles, first @%0t tone=%b active=%b", mis, mis_t, mis_tone, mis_act);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_in(0, 3'd0, 1'b0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_octave();
    test_midchange();
    test_release();
    test_retrigger();
    test_reset_midtone();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
